boot_sequencer: RTL and testbench
=================================

# boot_sequencer

Streams the PCW boot ROM image into the core's download port after every core reset, then pulses the execute strobe. It sits between the boot ROM (upstream) and the `pcw_core` `dn_*`/`execute_*` inputs (downstream). It replaces ad-hoc loader logic in the top level with a handshaked, abortable sequencer.

## Interface
Parameters:
- `BOOT_LEN`, 276: number of bytes transferred (addresses 0..BOOT_LEN-1).
- `ADDR_W`, 16: width of ROM and download addresses.

Ports:
- `clk_sys`, in, 1: system clock.
- `reset_n`, in, 1: asynchronous, active-low block reset.
- `core_reset`, in, 1: synchronous active-high core reset level; its falling edge starts a load.
- `model`, in, 1: system model select (0 = 8256/8512, 1 = 9256/9512+).
- `rom_addr`, out, ADDR_W: boot ROM byte address.
- `rom_model`, out, 1: model latched at load start, driven to the ROM.
- `rom_data`, in, 8: ROM data, valid one cycle after `rom_addr`.
- `dn_go`, out, 1: download in progress.
- `dn_wr`, out, 1: one-cycle write strobe.
- `dn_addr`, out, ADDR_W: write address.
- `dn_data`, out, 8: write data.
- `dn_wait`, in, 1: core back-pressure. While high, the next byte is held off.
- `execute_addr`, out, ADDR_W: start address, always 0.
- `execute_enable`, out, 1: one-cycle pulse after the last byte.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, FETCH, WAIT, WRITE, GAP, DONE.
- Byte counter `idx` runs 0..BOOT_LEN-1.
- IDLE:
  - All strobes are low.
  - A detected falling edge of `core_reset` loads `idx=0`, latches `rom_model<=model`, and moves to FETCH.
- FETCH:
  - `rom_addr=idx`, `dn_go=1`.
  - Next state is WAIT.
- WAIT: ROM access cycle. Next state is WRITE.
- WRITE:
  - `dn_wr=1`, `dn_addr=idx`, `dn_data=rom_data` (registered).
  - Next state is GAP.
- GAP:
  - `dn_wr=0`.
  - If `dn_wait=1`, stay in GAP.
  - Otherwise, if `idx==BOOT_LEN-1`, go to DONE.
  - Otherwise, increment `idx` and go to FETCH.
- DONE:
  - `dn_go=0`, `execute_enable=1` for exactly one cycle.
  - Next state is IDLE.
- `core_reset` high in any non-IDLE state aborts the load:
  - Next state is IDLE, `dn_go=0`, `dn_wr=0`.
  - No `execute_enable` is issued.
  - `idx` is not preserved. The next falling edge restarts from byte 0.
- Latching `rom_model` ensures a change on `model` during a load cannot mix images.
- `dn_wait` is sampled only in GAP. A WRITE strobe, once issued, always completes as a single cycle.
- Arithmetic:
  - `idx` is ADDR_W wide and never wraps; the terminal test is an equality compare.
  - BOOT_LEN must be ≥1 and ≤2^ADDR_W.

## Timing
- Reset values (`reset_n` low): state IDLE, `idx=0`, and every output 0 (`rom_addr`, `rom_model`, `dn_*`, `execute_addr`, `execute_enable`, `busy`).
- All outputs are registered.
- The edge detector registers `core_reset`. Let T0 be the first edge where the registered value is 0 and its previous value is 1. FETCH for byte 0 is active in the cycle after T0.
- Without back-pressure, each byte takes 4 cycles:
  - `dn_wr` for byte n is high at cycle T0+4n+3.
  - `execute_enable` is high at cycle T0+4·BOOT_LEN+1; 1105 for the default.
- Each cycle `dn_wait` is high in GAP adds exactly one cycle.
- `dn_go` rises with FETCH of byte 0 and falls on entry to DONE. It is high for the whole transfer, including GAP stalls.

## Structure
- Package `boot_seq_pkg`:
  - State enum `boot_state_t`.
  - `BOOT_LEN_DEFAULT = 276`.
  - `EXEC_ADDR = 16'h0000`.
- One sub-module: the codebase's existing `edge_det`, instantiated for the `core_reset` falling edge.
- Everything else stays in `boot_sequencer`.

## Test plan
- Reset/idle: `reset_n` low, then high with `core_reset` held high → all outputs 0 and `busy=0` indefinitely.
- Nominal load with BOOT_LEN=276 and a ROM model returning `data = addr[7:0] ^ {7'b0,model}`:
  - Drop `core_reset` → 276 `dn_wr` pulses.
  - `dn_addr` takes values 0..275 with matching data.
  - `execute_enable` is a single pulse 1105 cycles after T0.
  - `execute_addr=0`.
- Back-pressure: hold `dn_wait=1` for 10 cycles at byte 100's GAP → no `dn_wr` during the stall; byte 101 written 10 cycles later; `execute_enable` delayed by exactly 10 cycles.
- Abort: raise `core_reset` at byte 50 → `dn_go`/`dn_wr` low next cycle and no `execute_enable`. A later falling edge restarts at `dn_addr=0` and completes all 276 bytes.
- Model latch: toggle `model` at byte 10 → `rom_model` keeps its start value for the entire load.
- Async reset mid-load: pull `reset_n` low at byte 200 → all outputs 0 immediately (no clock needed), and no `execute_enable` after release.

Source files
------------

// File: rtl/boot_seq_pkg.sv
// Shared types and constants for the boot ROM download sequencer.
//   boot_state_t     : sequencer FSM state encoding
//   BOOT_LEN_DEFAULT : size of the PCW boot image in bytes
//   EXEC_ADDR        : address handed to the core's execute port
package boot_seq_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StWait,
        StWrite,
        StGap,
        StDone
    } boot_state_t;

    localparam int unsigned BOOT_LEN_DEFAULT = 276;
    localparam logic [15:0] EXEC_ADDR        = 16'h0000;

endpackage

// File: rtl/edge_det.sv
// Registered falling-edge detector.
//   clk_i  : clock
//   rst_ni : asynchronous active-low reset
//   d_i    : level to watch
//   fall_o : high for one cycle while the registered level is 0 and its previous value was 1
module edge_det (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic fall_o
);

    logic d_q;
    logic d_prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            d_q      <= 1'b0;
            d_prev_q <= 1'b0;
        end else begin
            d_q      <= d_i;
            d_prev_q <= d_q;
        end
    end

    assign fall_o = ~d_q & d_prev_q;

endmodule

// File: rtl/boot_sequencer.sv
// Streams the boot ROM image into the core download port after each core reset,
// then pulses the execute strobe.
//   clk_sys, reset_n         : clock, asynchronous active-low reset
//   core_reset               : core reset level; falling edge starts a load, high aborts it
//   model                    : system model select, latched onto rom_model at load start
//   rom_addr/rom_model       : boot ROM request; rom_data arrives one cycle later
//   dn_go/dn_wr/dn_addr/dn_data, dn_wait : core download port with back-pressure
//   execute_addr/execute_enable          : start address and one-cycle run strobe
//   busy                     : sequencer not idle
module boot_sequencer
    import boot_seq_pkg::*;
#(
    parameter int unsigned BOOT_LEN = BOOT_LEN_DEFAULT,
    parameter int unsigned ADDR_W   = 16
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              core_reset,
    input  logic              model,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_model,
    input  logic [7:0]        rom_data,
    output logic              dn_go,
    output logic              dn_wr,
    output logic [ADDR_W-1:0] dn_addr,
    output logic [7:0]        dn_data,
    input  logic              dn_wait,
    output logic [ADDR_W-1:0] execute_addr,
    output logic              execute_enable,
    output logic              busy
);

    localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(BOOT_LEN - 1);

    boot_state_t       state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              rom_model_q, rom_model_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [ADDR_W-1:0] dn_addr_q, dn_addr_d;
    logic [7:0]        dn_data_q, dn_data_d;
    logic              dn_go_q, dn_go_d;
    logic              dn_wr_q, dn_wr_d;
    logic              exec_q, exec_d;
    logic              busy_q, busy_d;
    logic              cr_fall;

    edge_det u_core_reset_edge (
        .clk_i  (clk_sys),
        .rst_ni (reset_n),
        .d_i    (core_reset),
        .fall_o (cr_fall)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        rom_model_d = rom_model_q;

        if (state_q != StIdle && core_reset) begin
            // Abort: drop everything, the next load restarts from byte 0.
            state_d = StIdle;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cr_fall) begin
                        state_d     = StFetch;
                        idx_d       = '0;
                        rom_model_d = model;
                    end
                end
                StFetch: state_d = StWait;
                StWait:  state_d = StWrite;
                StWrite: state_d = StGap;
                StGap: begin
                    if (!dn_wait) begin
                        if (idx_q == LastIdx) begin
                            state_d = StDone;
                        end else begin
                            idx_d   = idx_q + ADDR_W'(1);
                            state_d = StFetch;
                        end
                    end
                end
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end

        // Outputs are decoded from the next state so they are registered with it.
        rom_addr_d = (state_d == StFetch) ? idx_d : rom_addr_q;
        dn_addr_d  = (state_d == StWrite) ? idx_d : dn_addr_q;
        // ROM data is valid during WAIT, captured on the edge into WRITE.
        dn_data_d  = (state_d == StWrite) ? rom_data : dn_data_q;
        dn_go_d    = (state_d == StFetch) || (state_d == StWait) ||
                     (state_d == StWrite) || (state_d == StGap);
        dn_wr_d    = (state_d == StWrite);
        exec_d     = (state_d == StDone);
        busy_d     = (state_d != StIdle);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rom_model_q <= 1'b0;
            rom_addr_q  <= '0;
            dn_addr_q   <= '0;
            dn_data_q   <= '0;
            dn_go_q     <= 1'b0;
            dn_wr_q     <= 1'b0;
            exec_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            rom_model_q <= rom_model_d;
            rom_addr_q  <= rom_addr_d;
            dn_addr_q   <= dn_addr_d;
            dn_data_q   <= dn_data_d;
            dn_go_q     <= dn_go_d;
            dn_wr_q     <= dn_wr_d;
            exec_q      <= exec_d;
            busy_q      <= busy_d;
        end
    end

    assign rom_addr       = rom_addr_q;
    assign rom_model      = rom_model_q;
    assign dn_go          = dn_go_q;
    assign dn_wr          = dn_wr_q;
    assign dn_addr        = dn_addr_q;
    assign dn_data        = dn_data_q;
    assign execute_addr   = ADDR_W'(EXEC_ADDR);
    assign execute_enable = exec_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed bench for boot_sequencer: table of full loads (model, stall, model toggle)
// plus hand-written reset, abort and asynchronous-reset sequences.
module tb_boot_sequencer;

    localparam int L = 276;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        core_reset;
    logic        model;
    logic [15:0] rom_addr;
    logic        rom_model;
    logic [7:0]  rom_data;
    logic        dn_go;
    logic        dn_wr;
    logic [15:0] dn_addr;
    logic [7:0]  dn_data;
    logic        dn_wait;
    logic [15:0] execute_addr;
    logic        execute_enable;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    boot_sequencer #(.BOOT_LEN(L), .ADDR_W(16)) dut (
        .clk_sys        (clk_sys),
        .reset_n        (reset_n),
        .core_reset     (core_reset),
        .model          (model),
        .rom_addr       (rom_addr),
        .rom_model      (rom_model),
        .rom_data       (rom_data),
        .dn_go          (dn_go),
        .dn_wr          (dn_wr),
        .dn_addr        (dn_addr),
        .dn_data        (dn_data),
        .dn_wait        (dn_wait),
        .execute_addr   (execute_addr),
        .execute_enable (execute_enable),
        .busy           (busy)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) cyc <= cyc + 1;

    // Synchronous ROM model: data one cycle after address.
    always @(posedge clk_sys) rom_data <= rom_addr[7:0] ^ {7'b0, rom_model};

    typedef struct {
        bit m;
        int stall_byte;
        int stall_len;
        int toggle_byte;
        int exp_writes;
        int exp_exec_off;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [69:0] all_outs();
        return {rom_addr, rom_model, dn_go, dn_wr, dn_addr, dn_data, execute_addr,
                execute_enable, busy};
    endfunction

    // Runs one complete load from the core_reset falling edge and checks it.
    task automatic load_and_check(input vec_t v, input string tag);
        int t0, off, n_wr, n_exec, exec_off, extra, stall_cnt;
        int bad_wr, bad_model, bad_go, bad_busy, bad_xa;
        bit go_exp, busy_exp;
        logic [7:0] exp_d;
        n_wr = 0; n_exec = 0; exec_off = -1; extra = 0; stall_cnt = 0;
        bad_wr = 0; bad_model = 0; bad_go = 0; bad_busy = 0; bad_xa = 0;
        model   = v.m;
        dn_wait = 1'b0;
        @(negedge clk_sys);
        core_reset = 1'b0;
        t0 = cyc + 1;
        for (int k = 0; k < v.exp_exec_off + 6; k++) begin
            @(negedge clk_sys);
            off = cyc - t0;
            if (stall_cnt > 0) begin
                stall_cnt--;
                if (stall_cnt == 0) dn_wait = 1'b0;
            end
            go_exp   = (off >= 1) && (n_exec == 0) && !execute_enable;
            busy_exp = (off >= 1) && (n_exec == 0);
            if (dn_go !== go_exp) bad_go++;
            if (busy !== busy_exp) bad_busy++;
            if (off >= 1 && rom_model !== v.m) bad_model++;
            if (execute_addr !== 16'h0000) bad_xa++;
            if (dn_wr) begin
                exp_d = 8'(n_wr) ^ {7'b0, v.m};
                if (dn_addr !== 16'(n_wr) || dn_data !== exp_d ||
                    off != 3 + 4 * n_wr + extra) begin
                    if (bad_wr == 0)
                        $display("  %s byte %0d: addr %0d data %h off %0d", tag, n_wr,
                                 dn_addr, dn_data, off);
                    bad_wr++;
                end
                if (n_wr == v.stall_byte) begin
                    dn_wait   = 1'b1;
                    stall_cnt = v.stall_len + 1;
                    extra     = extra + v.stall_len;
                end
                if (n_wr == v.toggle_byte) model = ~v.m;
                n_wr++;
            end
            if (execute_enable) begin
                n_exec++;
                exec_off = off;
            end
        end
        core_reset = 1'b1;
        dn_wait    = 1'b0;
        repeat (3) @(negedge clk_sys);
        check({tag, "_writes"}, n_wr, v.exp_writes);
        check({tag, "_bad_writes"}, bad_wr, 0);
        check({tag, "_exec_pulses"}, n_exec, 1);
        check({tag, "_exec_offset"}, exec_off, v.exp_exec_off);
        check({tag, "_dn_go_bad"}, bad_go, 0);
        check({tag, "_busy_bad"}, bad_busy, 0);
        check({tag, "_rom_model_bad"}, bad_model, 0);
        check({tag, "_exec_addr_bad"}, bad_xa, 0);
    endtask

    initial begin
        vec_t vecs[5];
        int   cnt_a, cnt_b, bad_idle;
        bit   found;

        // model, stall byte, stall len, toggle byte, writes, execute offset from T0
        vecs[0] = '{1'b0, -1,  0, -1, 276, 1105};
        vecs[1] = '{1'b1, -1,  0, -1, 276, 1105};
        vecs[2] = '{1'b0, 100, 10, -1, 276, 1115};
        vecs[3] = '{1'b1, 0,   3, -1, 276, 1108};
        vecs[4] = '{1'b0, 275, 5, 10, 276, 1110};

        // Reset and idle with core_reset held high.
        reset_n    = 1'b0;
        core_reset = 1'b1;
        model      = 1'b1;
        dn_wait    = 1'b0;
        #1;
        check("reset_outputs", all_outs(), 0);
        repeat (3) @(negedge clk_sys);
        check("reset_busy", busy, 0);
        reset_n = 1'b1;
        bad_idle = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk_sys);
            if (all_outs() != 0) bad_idle++;
        end
        check("idle_outputs", bad_idle, 0);

        for (int i = 0; i < 5; i++) load_and_check(vecs[i], $sformatf("vec%0d", i));

        // Abort at byte 50, then restart from byte 0.
        model = 1'b0;
        @(negedge clk_sys);
        core_reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 600 && !found; k++) begin
            @(negedge clk_sys);
            if (dn_wr && dn_addr == 16'd50) found = 1'b1;
        end
        check("abort_reached_byte50", found, 1);
        core_reset = 1'b1;
        @(negedge clk_sys);
        check("abort_dn_go", dn_go, 0);
        check("abort_dn_wr", dn_wr, 0);
        check("abort_busy", busy, 0);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk_sys);
            if (execute_enable) cnt_a++;
            if (dn_wr || dn_go) cnt_b++;
        end
        check("abort_no_exec", cnt_a, 0);
        check("abort_no_writes", cnt_b, 0);
        load_and_check(vecs[0], "restart");

        // Asynchronous reset in the middle of a load.
        model = 1'b1;
        @(negedge clk_sys);
        core_reset = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk_sys);
            if (dn_wr && dn_addr == 16'd200) found = 1'b1;
        end
        check("areset_reached_byte200", found, 1);
        #2 reset_n = 1'b0;
        #1;
        check("areset_outputs", all_outs(), 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 1200; k++) begin
            @(negedge clk_sys);
            if (execute_enable) cnt_a++;
            if (busy) cnt_b++;
        end
        check("areset_no_exec", cnt_a, 0);
        check("areset_stays_idle", cnt_b, 0);
        core_reset = 1'b1;
        repeat (2) @(negedge clk_sys);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
